screen_sequence_checker: RTL
============================

Name: screen_sequence_checker

Overview:
- Downstream consumer of the LFSR bottom-screen generator in the bomb-defuse game.
- Captures the four 2-bit screen symbols at the start of each round, then checks the player's guesses against them in order (First to Fourth).
- Counts strikes and reports DEFUSED or EXPLODED to the top-level game controller and display logic.

Parameters:
- MAX_STRIKES, 3, strikes that cause EXPLODED; legal range 1..7.
- TIMEOUT_CYCLES, 50000000, idle cycles allowed per guess; used only when TIMEOUT_EN is defined.

Ports:
- Clk  input  1  system clock.
- Rst  input  1  asynchronous active-low reset.
- First_Screen  input  2  screen symbol 0 from the LFSR block.
- Second_Screen  input  2  screen symbol 1.
- Third_Screen  input  2  screen symbol 2.
- Fourth_Screen  input  2  screen symbol 3.
- New_Round  input  1  one-cycle pulse, already debounced; latches the screens and arms the checker.
- Guess_Valid  input  1  one-cycle pulse, already debounced; Guess is sampled on this cycle.
- Guess  input  2  player's symbol.
- Stage  output  3  number of symbols matched so far, 0..4.
- Strike  output  1  one-cycle pulse on each strike.
- Strike_Count  output  3  strikes accumulated in the current game.
- Armed  output  1  high while in the ARMED state.
- Defused  output  1  level, high in the DEFUSED state.
- Exploded  output  1  level, high in the EXPLODED state.

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; Stage=0, Strike=0, Strike_Count=0, Armed=0, Defused=0, Exploded=0; latched symbols cleared to 0.
- All outputs are registered. Every response appears on the clock edge after the input pulse is sampled, i.e. 1-cycle latency.
- States: IDLE, ARMED, DEFUSED, EXPLODED.
- IDLE:
  - Guess_Valid is ignored.
  - New_Round: latch all four screens, Stage=0, Strike_Count=0, go to ARMED.
- ARMED, on Guess_Valid:
  - Guess is compared with latched symbol[Stage].
  - Match with Stage<3: Stage increments.
  - Match with Stage==3: Stage=4, go to DEFUSED.
  - Mismatch: Strike pulses for one cycle, Strike_Count increments, Stage=0 (the sequence restarts).
  - Mismatch when the new Strike_Count equals MAX_STRIKES: go to EXPLODED; Strike still pulses on the same edge.
- ARMED, on New_Round: re-latch the screens, Stage=0, Strike_Count retained. Used when the player rerolls the screens.
- DEFUSED and EXPLODED:
  - Terminal; Guess_Valid is ignored.
  - New_Round: re-latch, clear Stage and Strike_Count, go to ARMED.
- Simultaneous New_Round and Guess_Valid: New_Round wins; the guess is dropped with no strike.
- Screen inputs may change at any time. Only the values present in the New_Round cycle are used.
- Strike_Count saturates at MAX_STRIKES.
- Stage never exceeds 4.
- Reset mid-round returns the block to IDLE immediately; no Strike pulse is emitted.

Optional Feature:
- Macro: SCREEN_GUESS_TIMEOUT_EN.
- Defined:
  - A guess-timeout counter runs while ARMED. It reloads to TIMEOUT_CYCLES-1 on entry to ARMED, on every Guess_Valid and on New_Round.
  - When the counter reaches 0 with no Guess_Valid in that cycle, the result is identical to a mismatch: Strike pulse, Strike_Count+1, Stage=0, EXPLODED if the limit is reached. The counter then reloads.
  - The counter is held at reload value outside ARMED.
- Not defined: no counter logic; TIMEOUT_CYCLES is unused; guesses may take unlimited time.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, ARMED=2'd1, DEFUSED=2'd2, EXPLODED=2'd3.
  - SYMBOL_W=2 and NUM_SCREENS=4, also used by the LFSR screen block and the display decoder.
- Sub-module: guess_timeout_counter.
  - Loadable down-counter with reload and enable inputs and a zero flag.
  - Instantiated only under SCREEN_GUESS_TIMEOUT_EN.
- The 4-entry symbol register and the compare mux stay inline.

Test Plan:
- Reset then New_Round with screens 2,0,3,1; guesses 2,0,3,1 -> Stage steps 1,2,3,4; Defused=1 one cycle after the 4th guess; Strike never pulses.
- Screens 1,1,2,3; guesses 1,3 -> after guess 3: Strike one-cycle pulse, Strike_Count=1, Stage=0, Armed=1.
- MAX_STRIKES=3; three wrong guesses in a row -> Strike_Count 1,2,3; Exploded=1 on the edge after the 3rd guess; a further Guess_Valid -> no change.
- New_Round and Guess_Valid in the same cycle while ARMED at Stage=2 -> Stage=0, screens re-latched, no Strike, Strike_Count unchanged.
- Screens change two cycles after New_Round; guesses matching the original values -> Defused=1, proving the latch holds.
- With SCREEN_GUESS_TIMEOUT_EN and TIMEOUT_CYCLES=10, arm and give no guesses -> Strike at cycles 10, 20 and 30 after arming; Exploded=1 after the 3rd; Rst=0 asserted at cycle 15 instead -> all outputs 0 immediately.

Source files
------------

// File: rtl/screen_sequence_checker_pkg.sv
// ---------------------------------------------------------------------------
// screen_sequence_checker_pkg
//
// Purpose:
//   Definitions shared by the bomb-defuse screen blocks: the LFSR screen
//   generator, this sequence checker and the display decoder.
//
// Contents:
//   SYMBOL_W, NUM_SCREENS - geometry of the bottom-screen symbol row
//   STAGE_W, STRIKE_W     - widths of the checker's progress counters
//   symbol_t              - one screen symbol
//   state_t               - checker states (IDLE/ARMED/DEFUSED/EXPLODED)
//   strike_inc()          - saturating strike-counter increment
// ---------------------------------------------------------------------------
package screen_sequence_checker_pkg;

  localparam int SYMBOL_W    = 2;
  localparam int NUM_SCREENS = 4;
  localparam int STAGE_W     = 3;
  localparam int STRIKE_W    = 3;

  typedef logic [SYMBOL_W-1:0] symbol_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DEFUSED  = 2'd2,
    EXPLODED = 2'd3
  } state_t;

  // Strike count never climbs past the explosion limit.
  function automatic logic [STRIKE_W-1:0] strike_inc(
    input logic [STRIKE_W-1:0] count,
    input logic [STRIKE_W-1:0] limit
  );
    return (count >= limit) ? limit : count + STRIKE_W'(1);
  endfunction

endpackage

// File: rtl/guess_timeout_counter.sv
// ---------------------------------------------------------------------------
// guess_timeout_counter
//
// Purpose:
//   Loadable down-counter that measures how long the player has been
//   sitting on a guess. Stops at zero and flags it; reload wins over enable.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   reload     in   load load_value on the next edge
//   enable     in   count down by one per cycle while nonzero
//   load_value in   WIDTH-bit reload value
//   zero       out  counter currently holds zero
// ---------------------------------------------------------------------------
module guess_timeout_counter
  import screen_sequence_checker_pkg::*;
#(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reload,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Down-count with reload priority; parks at zero until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (reload) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/screen_sequence_checker.sv
// ---------------------------------------------------------------------------
// screen_sequence_checker
//
// Purpose:
//   Latches the four bottom-screen symbols at the start of a round, checks
//   the player's guesses against them in order, counts strikes and reports
//   DEFUSED / EXPLODED. All outputs are registered (1-cycle latency).
//
// Parameters:
//   MAX_STRIKES    - strikes that explode the bomb (1..7)
//   TIMEOUT_CYCLES - idle cycles allowed per guess (timeout option only)
//
// Optional feature (macro SCREEN_GUESS_TIMEOUT_EN):
//   When defined, a guess that does not arrive within TIMEOUT_CYCLES cycles
//   of arming / the previous guess counts as a wrong guess.
//
// Ports:
//   Clk            in   system clock
//   Rst            in   asynchronous active-low reset
//   First_Screen   in   screen symbol 0 .. Fourth_Screen symbol 3
//   New_Round      in   pulse: latch screens and arm
//   Guess_Valid    in   pulse: Guess is valid this cycle
//   Guess          in   player's symbol
//   Stage          out  symbols matched so far (0..4)
//   Strike         out  one-cycle pulse per strike
//   Strike_Count   out  strikes in the current game
//   Armed          out  ARMED state
//   Defused        out  DEFUSED state
//   Exploded       out  EXPLODED state
// ---------------------------------------------------------------------------
module screen_sequence_checker
  import screen_sequence_checker_pkg::*;
#(
  parameter int MAX_STRIKES    = 3,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [SYMBOL_W-1:0] First_Screen,
  input  logic [SYMBOL_W-1:0] Second_Screen,
  input  logic [SYMBOL_W-1:0] Third_Screen,
  input  logic [SYMBOL_W-1:0] Fourth_Screen,
  input  logic                New_Round,
  input  logic                Guess_Valid,
  input  logic [SYMBOL_W-1:0] Guess,
  output logic [STAGE_W-1:0]  Stage,
  output logic                Strike,
  output logic [STRIKE_W-1:0] Strike_Count,
  output logic                Armed,
  output logic                Defused,
  output logic                Exploded
);

  localparam logic [STRIKE_W-1:0] MAX_COUNT  = STRIKE_W'(MAX_STRIKES);
  localparam logic [STAGE_W-1:0]  LAST_STAGE = STAGE_W'(NUM_SCREENS - 1);
  localparam logic [STAGE_W-1:0]  DONE_STAGE = STAGE_W'(NUM_SCREENS);

  state_t              state;
  symbol_t             symbols [NUM_SCREENS];
  symbol_t             current_symbol;
  logic                symbol_match;
  logic                guess_hit;
  logic                guess_miss;
  logic                timeout_fire;
  logic [STRIKE_W-1:0] strike_next;

  // Screens are captured only in the New_Round cycle, whatever the state,
  // so the LFSR may keep scrambling its outputs during play.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_SCREENS; i++) begin
        symbols[i] <= '0;
      end
    end else if (New_Round) begin
      symbols[0] <= First_Screen;
      symbols[1] <= Second_Screen;
      symbols[2] <= Third_Screen;
      symbols[3] <= Fourth_Screen;
    end
  end

  // Stage stays 0..3 while ARMED, so its low bits index the symbol row.
  assign current_symbol = symbols[Stage[1:0]];
  assign symbol_match   = (Guess == current_symbol);
  assign guess_hit      = Guess_Valid && symbol_match;
  assign guess_miss     = (Guess_Valid && !symbol_match) || timeout_fire;
  assign strike_next    = strike_inc(Strike_Count, MAX_COUNT);

`ifdef SCREEN_GUESS_TIMEOUT_EN
  localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic timeout_zero;
  logic timeout_reload;
  logic timeout_enable;

  // Held at the reload value outside ARMED; restarted by any guess, a new
  // round, or its own expiry.
  assign timeout_enable = (state == ARMED);
  assign timeout_reload = (state != ARMED) || Guess_Valid || New_Round || timeout_zero;
  assign timeout_fire   = (state == ARMED) && timeout_zero && !Guess_Valid && !New_Round;

  guess_timeout_counter #(
    .WIDTH(TIMEOUT_W)
  ) u_guess_timeout (
    .clk       (Clk),
    .rst_n     (Rst),
    .reload    (timeout_reload),
    .enable    (timeout_enable),
    .load_value(TIMEOUT_W'(TIMEOUT_CYCLES - 1)),
    .zero      (timeout_zero)
  );
`else
  // A guess may take as long as the player likes.
  assign timeout_fire = 1'b0;

  // TIMEOUT_CYCLES only matters when the timeout option is built in; it is
  // referenced here so both builds share one parameter list.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
  end
`endif

  // Main FSM. New_Round has priority over a guess in the same cycle, and the
  // state flags are registered alongside every state change.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state        <= IDLE;
      Stage        <= '0;
      Strike       <= 1'b0;
      Strike_Count <= '0;
      Armed        <= 1'b0;
      Defused      <= 1'b0;
      Exploded     <= 1'b0;
    end else begin
      Strike <= 1'b0;
      case (state)
        IDLE, DEFUSED, EXPLODED: begin
          if (New_Round) begin
            state        <= ARMED;
            Stage        <= '0;
            Strike_Count <= '0;
            Armed        <= 1'b1;
            Defused      <= 1'b0;
            Exploded     <= 1'b0;
          end
        end
        ARMED: begin
          if (New_Round) begin
            // Reroll: the sequence restarts but strikes carry over.
            Stage <= '0;
          end else if (guess_hit) begin
            if (Stage == LAST_STAGE) begin
              Stage   <= DONE_STAGE;
              state   <= DEFUSED;
              Armed   <= 1'b0;
              Defused <= 1'b1;
            end else begin
              Stage <= Stage + STAGE_W'(1);
            end
          end else if (guess_miss) begin
            Strike       <= 1'b1;
            Stage        <= '0;
            Strike_Count <= strike_next;
            if (strike_next == MAX_COUNT) begin
              state    <= EXPLODED;
              Armed    <= 1'b0;
              Exploded <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
